bram_1rw_req: RTL and testbench

- Requester-side controller for the single-port bram_1rw memory.
- Converts a valid/ready request stream (reads and writes) into the memory's ena/wea/addra/dina strobes.
- Captures read data returned on douta one cycle after issue and queues it in a response FIFO with valid/ready backpressure, so no read data is lost when the consumer stalls.
- Sits between cache/key-store logic and the bram_1rw instance.

---
 rtl/bram_1rw_req.sv | 98 +++++++++
 tb/tb_bram_1rw_req.sv | 197 +++++++++++++++++++
 2 files changed

// File: rtl/bram_1rw_req.sv
// Requester-side controller for a single-port block RAM: turns a valid/ready request
// stream into memory strobes and buffers the 1-cycle-latency read data in a credit-limited FIFO.
module bram_1rw_req #(
  parameter int unsigned ADDR_WIDTH = 6,
  parameter int unsigned DATA_WIDTH = 256,
  parameter int unsigned RSP_DEPTH  = 4
) (
  input  logic                  clka,
  input  logic                  rsta,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic                  busy,
  output logic                  mem_ena,
  output logic                  mem_wea,
  output logic [ADDR_WIDTH-1:0] mem_addra,
  output logic [DATA_WIDTH-1:0] mem_dina,
  input  logic [DATA_WIDTH-1:0] mem_douta
);

  localparam int unsigned PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  logic [CW-1:0]         count_q, count_d;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  inflight_q, inflight_d;
  logic [DATA_WIDTH-1:0] fifo_q [RSP_DEPTH];

  logic          fire;
  logic          fifo_empty;
  logic          credit_ok;
  logic          push;
  logic          pop;
  logic [CW:0]   used;
  logic [CW:0]   depth_lim;

  assign depth_lim  = RSP_DEPTH[CW:0];
  assign used       = {1'b0, count_q} + {{CW{1'b0}}, inflight_q};
  assign credit_ok  = used < depth_lim;
  assign fifo_empty = (count_q == '0);

  // No combinational path from rsp_ready into req_ready: credit uses registered state only.
  assign req_ready = !rsta && (req_we || credit_ok);
  assign fire      = req_valid && req_ready;

  assign mem_ena   = fire;
  assign mem_wea   = req_we;
  assign mem_addra = req_addr;
  assign mem_dina  = req_wdata;

  assign rsp_valid = !rsta && (inflight_q || !fifo_empty);
  assign busy      = !rsta && (inflight_q || !fifo_empty);
  assign rsp_rdata = fifo_empty ? mem_douta : fifo_q[rd_ptr_q];

  // Bypassed douta that the consumer takes directly never enters the FIFO.
  assign pop  = !rsta && !fifo_empty && rsp_ready;
  assign push = !rsta && inflight_q && !(fifo_empty && rsp_ready);

  always_comb begin
    inflight_d = fire && !req_we;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clka) begin
    if (rsta) begin
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      inflight_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      inflight_q <= inflight_d;
    end
  end

  // Storage needs no reset: entries are only visible through the cleared pointers/count.
  always_ff @(posedge clka) begin
    if (push) fifo_q[wr_ptr_q] <= mem_douta;
  end

endmodule

// File: tb/tb_bram_1rw_req.sv
// Directed vector table plus a randomized reference-model phase for bram_1rw_req,
// with a behavioural single-port RAM attached to the memory strobes.
module tb_bram_1rw_req;

  localparam int unsigned AW = 6;
  localparam int unsigned DW = 256;

  logic          clka = 1'b0;
  logic          rsta;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid, rsp_ready;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          mem_ena, mem_wea;
  logic [AW-1:0] mem_addra;
  logic [DW-1:0] mem_dina, mem_douta;

  logic [DW-1:0] ram [64];

  int errors = 0;
  int checks = 0;

  always #5 clka = ~clka;

  bram_1rw_req #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RSP_DEPTH(4)) dut (
    .clka(clka), .rsta(rsta),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .busy(busy),
    .mem_ena(mem_ena), .mem_wea(mem_wea), .mem_addra(mem_addra),
    .mem_dina(mem_dina), .mem_douta(mem_douta)
  );

  always @(posedge clka) begin
    if (mem_ena) begin
      if (mem_wea) ram[mem_addra] <= mem_dina;
      mem_douta <= ram[mem_addra];
    end
  end

  typedef struct {
    logic          rst;
    logic          v;
    logic          we;
    logic [AW-1:0] a;
    logic [DW-1:0] wd;
    logic          rr;
    logic          e_rdy;
    logic          e_rv;
    logic [DW-1:0] e_rd;
    logic          e_busy;
    logic          e_ena;
    logic          e_wea;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic rst, input logic v, input logic we, input int a,
                              input logic [DW-1:0] wd, input logic rr, input logic e_rdy,
                              input logic e_rv, input logic [DW-1:0] e_rd, input logic e_busy,
                              input logic e_ena, input logic e_wea);
    vec_t t;
    t.rst = rst; t.v = v; t.we = we; t.a = AW'(a); t.wd = wd; t.rr = rr;
    t.e_rdy = e_rdy; t.e_rv = e_rv; t.e_rd = e_rd; t.e_busy = e_busy;
    t.e_ena = e_ena; t.e_wea = e_wea;
    vecs.push_back(t);
  endfunction

  task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  logic [DW-1:0] A5;
  logic [DW-1:0] ref_mem [64];
  logic [DW-1:0] q[$];

  initial begin
    A5 = {32{8'hA5}};
    rsta = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;

    // rst v we a wd rr | rdy rv rd busy ena wea
    add(1, 1, 0, 0, 0, 1,   0, 0, 0, 0, 0, 0);
    add(0, 1, 1, 5, A5, 1,  1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 5, 0, 1,   1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, A5, 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) add(0, 1, 1, i, DW'(i + 16), 1,  1, 0, 0, 0, 1, 1);
    for (int i = 0; i < 8; i++)
      add(0, 1, 0, i, 0, 1,  1, i > 0, (i > 0) ? DW'(i + 15) : '0, i > 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h17), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    // backpressure: four reads fill the credits, fifth read stalls, writes still pass
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,   1, 1, DW'(8'h10), 1, 1, 0);
    add(0, 1, 0, 2, 0, 0,   1, 1, DW'(8'h10), 1, 1, 0);
    add(0, 1, 0, 3, 0, 0,   1, 1, DW'(8'h10), 1, 1, 0);
    add(0, 1, 0, 4, 0, 0,   0, 1, DW'(8'h10), 1, 0, 0);
    add(0, 1, 0, 4, 0, 0,   0, 1, DW'(8'h10), 1, 0, 0);
    add(0, 1, 1, 9, DW'(8'h99), 0,  1, 1, DW'(8'h10), 1, 1, 1);
    add(0, 0, 0, 0, 0, 1,   0, 1, DW'(8'h10), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h11), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h12), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h13), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 4, 0, 1,   1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h14), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    // write X, read, write Y to the same address: queued response keeps X
    add(0, 1, 1, 3, DW'(8'h3A), 0,  1, 0, 0, 0, 1, 1);
    add(0, 1, 0, 3, 0, 0,   1, 0, 0, 0, 1, 0);
    add(0, 1, 1, 3, DW'(8'h3B), 0,  1, 1, DW'(8'h3A), 1, 1, 1);
    add(0, 1, 0, 3, 0, 0,   1, 1, DW'(8'h3A), 1, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h3A), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h3B), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    // reset with one read in flight and two queued
    add(0, 1, 0, 0, 0, 0,   1, 0, 0, 0, 1, 0);
    add(0, 1, 0, 1, 0, 0,   1, 1, DW'(8'h10), 1, 1, 0);
    add(0, 1, 0, 2, 0, 0,   1, 1, DW'(8'h10), 1, 1, 0);
    add(1, 0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);
    add(0, 1, 0, 6, 0, 1,   1, 0, 0, 0, 1, 0);
    add(0, 0, 0, 0, 0, 1,   1, 1, DW'(8'h16), 1, 0, 0);
    add(0, 0, 0, 0, 0, 1,   1, 0, 0, 0, 0, 0);

    repeat (2) @(negedge clka);

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clka);
      rsta = vecs[i].rst; req_valid = vecs[i].v; req_we = vecs[i].we;
      req_addr = vecs[i].a; req_wdata = vecs[i].wd; rsp_ready = vecs[i].rr;
      #1;
      chk($sformatf("v%0d req_ready", i), DW'(req_ready), DW'(vecs[i].e_rdy));
      chk($sformatf("v%0d rsp_valid", i), DW'(rsp_valid), DW'(vecs[i].e_rv));
      chk($sformatf("v%0d busy", i),      DW'(busy),      DW'(vecs[i].e_busy));
      chk($sformatf("v%0d mem_ena", i),   DW'(mem_ena),   DW'(vecs[i].e_ena));
      if (vecs[i].e_ena) chk($sformatf("v%0d mem_wea", i), DW'(mem_wea), DW'(vecs[i].e_wea));
      if (vecs[i].e_rv)  chk($sformatf("v%0d rsp_rdata", i), rsp_rdata, vecs[i].e_rd);
    end

    // random phase: initialise every address so the reference memory is fully known
    for (int a = 0; a < 64; a++) begin
      @(negedge clka);
      rsta = 1'b0; req_valid = 1'b1; req_we = 1'b1; req_addr = AW'(a);
      req_wdata = {8{$urandom}}; rsp_ready = 1'b1;
      ref_mem[a] = req_wdata;
    end

    for (int n = 0; n < 400; n++) begin
      logic [DW-1:0] head;
      @(negedge clka);
      req_valid = ($urandom_range(0, 3) != 0);
      req_we    = ($urandom_range(0, 2) == 0);
      req_addr  = AW'($urandom_range(0, 63));
      req_wdata = {8{$urandom}};
      rsp_ready = $urandom_range(0, 1) == 1;
      #1;
      chk("rnd rsp_valid", DW'(rsp_valid), DW'(q.size() != 0));
      chk("rnd busy", DW'(busy), DW'(q.size() != 0));
      if (req_valid) chk("rnd req_ready", DW'(req_ready), DW'(req_we || (q.size() < 4)));
      if (rsp_valid && rsp_ready && q.size() != 0) begin
        head = q.pop_front();
        chk("rnd rsp_rdata", rsp_rdata, head);
      end
      if (req_valid && req_ready) begin
        if (req_we) ref_mem[req_addr] = req_wdata;
        else        q.push_back(ref_mem[req_addr]);
      end
      if (q.size() > 4) chk("rnd credit", DW'(q.size()), DW'(4));
    end

    for (int n = 0; n < 20 && q.size() != 0; n++) begin
      logic [DW-1:0] head;
      @(negedge clka);
      req_valid = 1'b0; rsp_ready = 1'b1;
      #1;
      chk("drain rsp_valid", DW'(rsp_valid), DW'(1));
      head = q.pop_front();
      chk("drain rsp_rdata", rsp_rdata, head);
    end
    if (q.size() != 0) chk("drain timeout", DW'(q.size()), DW'(0));
    @(negedge clka);
    #1;
    chk("final busy", DW'(busy), DW'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
